// File: rtl/dbg_cmd_arbiter.sv
// dbg_cmd_arbiter: round-robin arbiter sharing the core debug command bus between N_REQ requesters.
// One command in flight at a time; every command is followed by a one-cycle bus drain.
module dbg_cmd_arbiter #(
    parameter int N_REQ          = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                clk,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_valid_i,
    input  logic [8*N_REQ-1:0]  req_cmd_i,
    input  logic [32*N_REQ-1:0] req_addr_i,
    input  logic [32*N_REQ-1:0] req_data_i,
    output logic [N_REQ-1:0]    rsp_valid_o,
    output logic                rsp_err_o,
    output logic [31:0]         rsp_data_o,
    output logic [7:0]          dbg_cmd_o,
    output logic [31:0]         dbg_addr_o,
    output logic [31:0]         dbg_data_o,
    input  logic [31:0]         dbg_data_i,
    input  logic                dbg_done_i,
    output logic                busy_o
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    state_t             r_state, w_state_n;
    logic [IW-1:0]      r_rr, w_rr_n, r_grant, w_grant_n;
    logic [CW-1:0]      r_cnt, w_cnt_n;
    logic [7:0]         r_cmd, w_cmd_n;
    logic [31:0]        r_addr, w_addr_n, r_data, w_data_n;
    logic [N_REQ-1:0]   r_rsp_valid, w_rsp_valid_n;
    logic               r_rsp_err, w_rsp_err_n;
    logic [31:0]        r_rsp_data, w_rsp_data_n;
    logic               r_busy;
    logic [N_REQ-1:0]   w_req;
    logic [IW:0]        w_pick;
    logic               w_found;
    logic [IW-1:0]      w_idx;
    logic [7:0]         w_cmd_sel;
    logic               w_legal;

    function automatic logic [IW:0] pick(input logic [N_REQ-1:0] v, input logic [IW-1:0] p);
        int j;
        pick = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(p) + k) % N_REQ;
            if (v[j]) pick = {1'b1, IW'(j)};
        end
    endfunction

    // A requester whose response is on the bus this cycle is still holding valid; keep it out.
    assign w_req     = req_valid_i & ~r_rsp_valid;
    assign w_pick    = pick(w_req, r_rr);
    assign w_found   = w_pick[IW];
    assign w_idx     = w_pick[IW-1:0];
    assign w_cmd_sel = req_cmd_i[8*w_idx +: 8];
    assign w_legal   = (w_cmd_sel != 8'h00) && (w_cmd_sel <= 8'h06);

    always_comb begin
        w_state_n     = r_state;
        w_rr_n        = r_rr;
        w_grant_n     = r_grant;
        w_cnt_n       = r_cnt;
        w_cmd_n       = r_cmd;
        w_addr_n      = r_addr;
        w_data_n      = r_data;
        w_rsp_valid_n = '0;
        w_rsp_err_n   = 1'b0;
        w_rsp_data_n  = '0;
        case (r_state)
            S_IDLE: if (w_found) begin
                w_grant_n = w_idx;
                w_rr_n    = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
                if (w_legal) begin
                    w_cmd_n   = w_cmd_sel;
                    w_addr_n  = req_addr_i[32*w_idx +: 32];
                    w_data_n  = req_data_i[32*w_idx +: 32];
                    w_cnt_n   = '0;
                    w_state_n = S_WAIT;
                end else begin
                    w_rsp_valid_n = N_REQ'(1) << w_idx;
                    w_rsp_err_n   = 1'b1;
                end
            end
            S_WAIT: begin
                w_cnt_n = r_cnt + 1'b1;
                if (dbg_done_i || r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    w_state_n     = S_DRAIN;
                    w_cmd_n       = '0;
                    w_addr_n      = '0;
                    w_data_n      = '0;
                    w_rsp_valid_n = N_REQ'(1) << r_grant;
                    w_rsp_err_n   = !dbg_done_i;
                    w_rsp_data_n  = (dbg_done_i && (r_cmd == 8'h03 || r_cmd == 8'h05)) ? dbg_data_i : '0;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_rr        <= '0;
            r_grant     <= '0;
            r_cnt       <= '0;
            r_cmd       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_rsp_valid <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_rr        <= w_rr_n;
            r_grant     <= w_grant_n;
            r_cnt       <= w_cnt_n;
            r_cmd       <= w_cmd_n;
            r_addr      <= w_addr_n;
            r_data      <= w_data_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_err   <= w_rsp_err_n;
            r_rsp_data  <= w_rsp_data_n;
            r_busy      <= (w_state_n != S_IDLE);
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_err_o   = r_rsp_err;
    assign rsp_data_o  = r_rsp_data;
    assign dbg_cmd_o   = r_cmd;
    assign dbg_addr_o  = r_addr;
    assign dbg_data_o  = r_data;
    assign busy_o      = r_busy;
endmodule

// File: tb/tb_dbg_cmd_arbiter.sv
// tb_dbg_cmd_arbiter: directed stimulus with a response scoreboard and a small core debug module model.
module tb_dbg_cmd_arbiter;
    logic         clk = 1'b0;
    logic         rst_i;
    logic [1:0]   req_valid_i;
    logic [15:0]  req_cmd_i;
    logic [63:0]  req_addr_i;
    logic [63:0]  req_data_i;
    logic [1:0]   rsp_valid_o;
    logic         rsp_err_o;
    logic [31:0]  rsp_data_o;
    logic [7:0]   dbg_cmd_o;
    logic [31:0]  dbg_addr_o;
    logic [31:0]  dbg_data_o;
    logic [31:0]  dbg_data_i;
    logic         dbg_done_i = 1'b0;
    logic         busy_o;

    dbg_cmd_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_cmd_i(req_cmd_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .rsp_valid_o(rsp_valid_o),
        .rsp_err_o(rsp_err_o), .rsp_data_o(rsp_data_o), .dbg_cmd_o(dbg_cmd_o),
        .dbg_addr_o(dbg_addr_o), .dbg_data_o(dbg_data_o), .dbg_data_i(dbg_data_i),
        .dbg_done_i(dbg_done_i), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // Core model: done rises dly cycles after the command appears and lingers one cycle after it drops.
    logic [31:0] core_rdata = 32'h0;
    int          dly = 1;
    bit          never = 1'b0;
    int          mcnt = 0;
    assign dbg_data_i = core_rdata;
    always @(posedge clk) begin
        dbg_done_i <= !never && dbg_cmd_o != 8'h00 && mcnt >= dly - 1;
        mcnt       <= (dbg_cmd_o != 8'h00) ? mcnt + 1 : 0;
    end

    typedef struct {
        int          idx;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];
    int pass = 0;
    int total = 0;

    initial forever begin
        @(negedge clk);
        if (rsp_valid_o != 2'b00) begin
            total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_rsp valid=%b err=%b data=%h", rsp_valid_o, rsp_err_o, rsp_data_o);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (rsp_valid_o == (2'b01 << e.idx) && rsp_err_o == e.err && rsp_data_o == e.data)
                    pass++;
                else
                    $display("FAIL rsp got valid=%b err=%b data=%h want valid=%b err=%b data=%h",
                             rsp_valid_o, rsp_err_o, rsp_data_o, 2'b01 << e.idx, e.err, e.data);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got === want) pass++;
        else $display("FAIL %s got=%h want=%h", name, got, want);
    endtask

    task automatic expect_rsp(input int idx, input logic err, input logic [31:0] data);
        exp_t e;
        e.idx = idx; e.err = err; e.data = data;
        q.push_back(e);
    endtask

    task automatic issue(input int idx, input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data);
        req_cmd_i[8*idx +: 8]   = cmd;
        req_addr_i[32*idx +: 32] = addr;
        req_data_i[32*idx +: 32] = data;
        req_valid_i[idx] = 1'b1;
    endtask

    task automatic wait_rsp(input int idx);
        bit seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(posedge clk); #1;
            if (rsp_valid_o[idx]) begin
                seen = 1'b1;
                req_valid_i[idx] = 1'b0;
            end
        end
        if (!seen) begin
            total++;
            $display("FAIL wait_rsp%0d timed out", idx);
            req_valid_i[idx] = 1'b0;
        end
    endtask

    task automatic step;
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        rst_i = 1'b1; req_valid_i = '0; req_cmd_i = '0; req_addr_i = '0; req_data_i = '0;
        step; step;
        chk("reset_cmd", 32'(dbg_cmd_o), 32'h0);
        chk("reset_rsp", {29'h0, rsp_valid_o, rsp_err_o}, 32'h0);
        chk("reset_busy", 32'(busy_o), 32'h0);
        rst_i = 1'b0;
        step;

        // halt from req0: cmd at t+1, response at t+3
        core_rdata = 32'h0000_1234; dly = 1;
        expect_rsp(0, 1'b0, 32'h0);
        issue(0, 8'h01, 32'h0, 32'h0);
        step;
        chk("t1_cmd_t1", 32'(dbg_cmd_o), 32'h01);
        chk("t1_busy", 32'(busy_o), 32'h1);
        step;
        chk("t1_norsp_t2", 32'(rsp_valid_o), 32'h0);
        step;
        chk("t1_rsp_t3", 32'(rsp_valid_o), 32'h1);
        chk("t1_cmd_t3", 32'(dbg_cmd_o), 32'h0);
        req_valid_i[0] = 1'b0;
        step; step;

        // register read from req1 with a slow core
        core_rdata = 32'hDEAD_BEEF; dly = 3;
        expect_rsp(1, 1'b0, 32'hDEAD_BEEF);
        issue(1, 8'h03, 32'd5, 32'h0);
        step;
        chk("t2_cmd", 32'(dbg_cmd_o), 32'h03);
        chk("t2_addr_w0", dbg_addr_o, 32'd5);
        step; step;
        chk("t2_addr_w2", dbg_addr_o, 32'd5);
        wait_rsp(1);
        step; step;

        // both requesters hold pc reads: grants alternate 0,1,0,1
        core_rdata = 32'hCAFE_0005; dly = 1;
        for (int i = 0; i < 4; i++) expect_rsp(i % 2, 1'b0, 32'hCAFE_0005);
        issue(0, 8'h05, 32'h0, 32'h0);
        issue(1, 8'h05, 32'h0, 32'h0);
        n = 0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            step;
            if (rsp_valid_o != 2'b00) begin
                chk("t3_gap_cmd", 32'(dbg_cmd_o), 32'h0);
                n++;
                if (n == 4) req_valid_i = '0;
            end
        end
        chk("t3_rsp_count", n, 4);
        req_valid_i = '0;
        step; step;

        // never-done core: error after exactly 8 WAIT cycles
        core_rdata = 32'h5555_AAAA; never = 1'b1;
        expect_rsp(0, 1'b1, 32'h0);
        issue(0, 8'h02, 32'd1, 32'h55);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            step;
            n++;
            if (rsp_valid_o != 2'b00) break;
        end
        chk("t4_timeout_lat", n, 9);
        chk("t4_cmd_after", 32'(dbg_cmd_o), 32'h0);
        req_valid_i[0] = 1'b0;
        never = 1'b0; dly = 1;
        step;
        chk("t4_drain_cmd", 32'(dbg_cmd_o), 32'h0);
        expect_rsp(1, 1'b0, 32'h0);
        issue(1, 8'h04, 32'd2, 32'h77);
        wait_rsp(1);
        step; step;

        // illegal command: immediate error, bus untouched, no duplicate while valid lingers
        expect_rsp(0, 1'b1, 32'h0);
        issue(0, 8'h07, 32'h0, 32'h0);
        step;
        chk("t5_rsp", 32'(rsp_valid_o), 32'h1);
        chk("t5_cmd", 32'(dbg_cmd_o), 32'h0);
        chk("t5_busy", 32'(busy_o), 32'h0);
        step;
        req_valid_i[0] = 1'b0;
        chk("t5_no_dup", 32'(rsp_valid_o), 32'h0);
        chk("t5_cmd2", 32'(dbg_cmd_o), 32'h0);
        step; step;

        // reset during WAIT aborts silently; the core's stale done is ignored
        dly = 1;
        issue(0, 8'h06, 32'd3, 32'h99);
        step;
        chk("t6_cmd", 32'(dbg_cmd_o), 32'h06);
        rst_i = 1'b1; req_valid_i = '0;
        step;
        rst_i = 1'b0;
        chk("t6_cmd_rst", 32'(dbg_cmd_o), 32'h0);
        chk("t6_addr_rst", dbg_addr_o, 32'h0);
        chk("t6_data_rst", dbg_data_o, 32'h0);
        chk("t6_rsp_rst", {29'h0, rsp_valid_o, rsp_err_o}, 32'h0);
        chk("t6_busy_rst", 32'(busy_o), 32'h0);
        for (int c = 0; c < 4; c++) begin
            step;
            chk("t6_quiet", {22'h0, busy_o, dbg_cmd_o, rsp_valid_o}, 32'h0);
        end
        expect_rsp(1, 1'b0, 32'h0);
        issue(1, 8'h01, 32'h0, 32'h0);
        wait_rsp(1);
        step; step; step;

        chk("scoreboard_empty", q.size(), 0);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule
